// File: rtl/ppg_window_sequencer.sv
// Windowed read sequencer for the PPG sample ROM: fetches a clipped address window and
// streams it over valid/ready through a 2-entry skid FIFO. Optional running sum: SEQ_SUM_EN.
module ppg_window_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 5968,
  parameter int ADDR_WIDTH   = 13
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [ADDR_WIDTH-1:0]            win_start,
  input  logic [ADDR_WIDTH-1:0]            win_len,
  input  logic                             mem_loaded,
  output logic [ADDR_WIDTH-1:0]            mem_read_address,
  input  logic [DATA_WIDTH-1:0]            mem_data,
  output logic [DATA_WIDTH-1:0]            sample_out,
  output logic                             sample_valid,
  input  logic                             sample_ready,
  output logic                             sample_last,
  output logic [ADDR_WIDTH-1:0]            sample_index,
  output logic                             busy,
  output logic                             done,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] sample_sum
);

  localparam logic [ADDR_WIDTH-1:0] LP_DEPTH = ADDR_WIDTH'(MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_ONE   = ADDR_WIDTH'(1);
  localparam int                    SUM_W    = DATA_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_LOAD, S_RUN, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [ADDR_WIDTH-1:0]  r_eff_len;
  logic [ADDR_WIDTH-1:0]  r_issue_cnt;
  logic [ADDR_WIDTH-1:0]  r_xfer_cnt;
  logic [ADDR_WIDTH-1:0]  r_last_addr;
  logic [DATA_WIDTH-1:0]  r_buf0;
  logic [DATA_WIDTH-1:0]  r_buf1;
  logic [1:0]             r_occ;
  logic                   r_inflight;

  logic [ADDR_WIDTH-1:0]  w_remain;
  logic [ADDR_WIDTH-1:0]  w_clip_len;
  logic                   w_empty;
  logic                   w_start_ok;
  logic                   w_pop;
  logic                   w_head_last;
  logic [2:0]             w_level;
  logic                   w_issue;
  logic [ADDR_WIDTH-1:0]  w_issue_addr;

  // Window clipped to the end of the ROM; an out-of-range start yields an empty window
  assign w_remain   = LP_DEPTH - win_start;
  assign w_clip_len = (win_start >= LP_DEPTH) ? '0 :
                      ((win_len < w_remain) ? win_len : w_remain);
  assign w_empty    = (w_clip_len == '0);
  assign w_start_ok = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign sample_valid = (r_occ != 2'd0);
  assign sample_out   = r_buf0;
  assign sample_index = r_xfer_cnt;
  assign w_head_last  = (r_xfer_cnt == (r_eff_len - LP_ONE));
  assign sample_last  = sample_valid && w_head_last;
  assign w_pop        = sample_valid && sample_ready && !abort;

  // Level counts the slot freed by this cycle's pop so a full-rate stream never stalls
  assign w_level      = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == S_RUN) && !abort && (r_issue_cnt < r_eff_len) &&
                        (w_level < 3'd2);
  assign w_issue_addr = r_base + r_issue_cnt;
  assign mem_read_address = w_issue ? w_issue_addr : r_last_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (w_empty)         w_state_next = S_DONE;
            else if (mem_loaded) w_state_next = S_RUN;
            else                 w_state_next = S_WAIT_LOAD;
          end
        end
        S_WAIT_LOAD: if (mem_loaded) w_state_next = S_RUN;
        S_RUN:       if (w_pop && w_head_last) w_state_next = S_DONE;
        default:     w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == S_WAIT_LOAD) || (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base      <= '0;
      r_eff_len   <= '0;
      r_issue_cnt <= '0;
      r_xfer_cnt  <= '0;
      r_last_addr <= '0;
    end else if (w_start_ok) begin
      r_base      <= win_start;
      r_eff_len   <= w_clip_len;
      r_issue_cnt <= '0;
      r_xfer_cnt  <= '0;
    end else begin
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + LP_ONE;
        r_last_addr <= w_issue_addr;
      end
      if (w_pop) r_xfer_cnt <= r_xfer_cnt + LP_ONE;
    end
  end

  // Skid FIFO: head in r_buf0; ROM data lands one cycle after its read was issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else if (abort) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      case ({w_pop, r_inflight})
        2'b10: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'd0) r_buf0 <= mem_data;
          else               r_buf1 <= mem_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= mem_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= mem_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_SUM_EN
  logic [SUM_W-1:0] r_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum <= '0;
    end else if (abort || w_start_ok) begin
      r_sum <= '0;
    end else if (w_pop) begin
      r_sum <= r_sum + SUM_W'(sample_out);
    end
  end

  assign sample_sum = r_sum;
`else
  assign sample_sum = {SUM_W{1'b0}};
`endif

endmodule

// File: tb/tb_ppg_window_sequencer.sv
// Directed bench for ppg_window_sequencer: a ROM model, a queue of expected window samples
// checked every cycle, and literal expectations for latency, clipping, wait-for-load and abort.
module tb_ppg_window_sequencer;
  localparam int DW    = 16;
  localparam int AW    = 13;
  localparam int DEPTH = 5968;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] win_start;
  logic [AW-1:0] win_len;
  logic          mem_loaded;
  logic [AW-1:0] mem_read_address;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          sample_ready;
  logic          sample_last;
  logic [AW-1:0] sample_index;
  logic          busy;
  logic          done;
  logic [DW+AW-1:0] sample_sum;

  ppg_window_sequencer #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .win_start(win_start), .win_len(win_len), .mem_loaded(mem_loaded),
    .mem_read_address(mem_read_address), .mem_data(mem_data),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_last(sample_last), .sample_index(sample_index),
    .busy(busy), .done(done), .sample_sum(sample_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] rom [0:DEPTH-1];
  initial mem_data = '0;
  always @(posedge clk) mem_data <= rom[mem_read_address];

  typedef struct {
    logic [DW-1:0] d;
    int            idx;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  int            checks;
  int            errors;
  longint        exp_sum;
  int            issued;
  int            xfers;
  int            last_seen_idx;
  bit            track;
  logic [AW-1:0] prev_addr;
  int            addr_hist[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int c);
    logic [5:0] p;
    p = 6'b101001;
    if (mode == 0) return 1'b1;
    return p[c % 6];
  endfunction

  // Per-cycle comparison of the stream head against the expected window contents
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("addr_range", 64'(mem_read_address < AW'(DEPTH)), 64'd1);
        if (track && mem_read_address != prev_addr) begin
          addr_hist.push_back(int'(mem_read_address));
          issued++;
          prev_addr = mem_read_address;
        end
        if (sample_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 64'(sample_valid), 64'd0);
          end else begin
            chk("data", 64'(sample_out), 64'(exp_q[0].d));
            chk("index", 64'(sample_index), 64'(exp_q[0].idx));
            chk("last", 64'(sample_last), 64'(exp_q[0].last));
            if (sample_ready && !abort) begin
              exp_sum += longint'(exp_q[0].d);
              if (exp_q[0].last) last_seen_idx = exp_q[0].idx;
              void'(exp_q.pop_front());
              xfers++;
            end
          end
        end
        if (track) chk("outstanding_le2", 64'((issued - xfers) <= 2), 64'd1);
      end
    end
  end

  int first_valid;
  int done_cyc;
  int eff;

  task automatic run_window(input int ws, input int wl, input int load_delay,
                            input int mode, input int abort_at);
    int cyc;
    logic [AW-1:0] addr0;
    if (ws >= DEPTH) eff = 0;
    else eff = (wl < DEPTH - ws) ? wl : DEPTH - ws;
    exp_q.delete();
    for (int i = 0; i < eff; i++) exp_q.push_back('{rom[ws + i], i, (i == eff - 1)});
    exp_sum = 0; issued = 0; xfers = 0; last_seen_idx = -1;
    addr_hist.delete();
    @(posedge clk); #1;
    prev_addr    = mem_read_address;
    addr0        = mem_read_address;
    start        = 1'b1;
    win_start    = AW'(ws);
    win_len      = AW'(wl);
    mem_loaded   = (load_delay == 0);
    sample_ready = ready_pat(mode, 0);
    track        = 1'b1;
    cyc = 0; first_valid = -1; done_cyc = -1;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == load_delay) mem_loaded = 1'b1;
      sample_ready = ready_pat(mode, cyc);
      abort = (cyc == abort_at);
      #1;
      if (first_valid < 0 && sample_valid) first_valid = cyc;
      if (load_delay > 0 && cyc <= load_delay) begin
        chk("wait_busy", 64'(busy), 64'd1);
        chk("wait_no_read", 64'(mem_read_address), 64'(addr0));
      end
      if (cyc == abort_at) chk("abort_head_valid", 64'(sample_valid), 64'd1);
      if (done && done_cyc < 0) done_cyc = cyc;
      if (abort_at > 0 && cyc == abort_at + 1) break;
      if (done_cyc > 0) break;
    end
    track = 1'b0;
    abort = 1'b0;
    if (abort_at > 0) begin
      chk("abort_valid_clr", 64'(sample_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      exp_q.delete();
    end else begin
      chk("window_timeout", 64'(done_cyc > 0), 64'd1);
      chk("all_samples", 64'(exp_q.size()), 64'd0);
      chk("done_flag", 64'(done), 64'd1);
      chk("busy_in_done", 64'(busy), 64'd0);
      if (eff == 0) begin
        chk("empty_done_cycle", 64'(done_cyc), 64'd1);
        chk("empty_no_valid", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("empty_addr_held", 64'(mem_read_address), 64'(addr0));
      end else begin
        chk("first_valid_lat", 64'(first_valid), 64'(load_delay + 3));
        if (mode == 0) chk("full_rate", 64'(done_cyc), 64'(first_valid + eff));
      end
`ifdef SEQ_SUM_EN
      chk("sum_model", 64'(sample_sum), 64'(exp_sum));
`endif
    end
  endtask

  initial begin
    checks = 0; errors = 0; track = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = DW'(i * 40503 + 7);
    rom[0] = 16'h0010; rom[1] = 16'h0020; rom[2] = 16'h0030; rom[3] = 16'h0040;
    reset = 1'b1; start = 1'b0; abort = 1'b0; win_start = '0; win_len = '0;
    mem_loaded = 1'b0; sample_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(sample_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(mem_read_address), 64'd0);
    chk("rst_last", 64'(sample_last), 64'd0);
    chk("rst_index", 64'(sample_index), 64'd0);
    chk("rst_sum", 64'(sample_sum), 64'd0);
    reset = 1'b0;

    run_window(0, 4, 0, 0, -1);
    chk("t1_first_valid", 64'(first_valid), 64'd3);
    chk("t1_done_cycle", 64'(done_cyc), 64'd7);
    chk("t1_last_idx", 64'(last_seen_idx), 64'd3);
`ifdef SEQ_SUM_EN
    chk("t1_sum", 64'(sample_sum), 64'h00A0);
`endif
    $display("window 0/4 ready=1: first_valid=%0d done=%0d", first_valid, done_cyc);

    run_window(0, 4, 0, 1, -1);
    chk("t2_last_idx", 64'(last_seen_idx), 64'd3);
    chk("t2_xfers", 64'(xfers), 64'd4);
    $display("window 0/4 ready toggling: done=%0d xfers=%0d", done_cyc, xfers);

    run_window(5966, 10, 0, 0, -1);
    chk("t3_eff_len", 64'(eff), 64'd2);
    chk("t3_reads", 64'(addr_hist.size()), 64'd2);
    if (addr_hist.size() == 2) begin
      chk("t3_addr0", 64'(addr_hist[0]), 64'd5966);
      chk("t3_addr1", 64'(addr_hist[1]), 64'd5967);
    end
    chk("t3_last_idx", 64'(last_seen_idx), 64'd1);
    $display("window 5966/10 clipped: reads=%0d done=%0d", addr_hist.size(), done_cyc);

    run_window(6000, 5, 0, 0, -1);
    $display("window 6000/5 empty: done=%0d", done_cyc);
    run_window(100, 0, 0, 0, -1);
    $display("window 100/0 empty: done=%0d", done_cyc);

    run_window(10, 6, 5, 0, -1);
    chk("t5_first_valid", 64'(first_valid), 64'd8);
    chk("t5_done_cycle", 64'(done_cyc), 64'd14);
    $display("window 10/6 load delayed 5: first_valid=%0d done=%0d", first_valid, done_cyc);

    run_window(0, 8, 0, 0, 5);
    chk("t6_xfers_before_abort", 64'(xfers), 64'd2);
`ifdef SEQ_SUM_EN
    chk("t6_sum_cleared", 64'(sample_sum), 64'd0);
`endif
    $display("window 0/8 aborted at 3rd sample: xfers=%0d", xfers);

    run_window(0, 8, 0, 0, -1);
    chk("t7_first_valid", 64'(first_valid), 64'd3);
    chk("t7_done_cycle", 64'(done_cyc), 64'd11);
    chk("t7_xfers", 64'(xfers), 64'd8);
    $display("window 0/8 replay: first_valid=%0d done=%0d", first_valid, done_cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
